io_confirm_ctrl: RTL

// - MMIO sequencer between Controller/ALU and the board I/O. It decodes IO accesses by address.
// - Switch reads stall the core (stall -> IFetch) until a debounced confirm pulse arrives, then return the latched switches.
// - Owns the LED and 7-seg data registers that feed the LED and scan4 drivers.

---
 rtl/io_confirm_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/io_confirm_ctrl.sv
// -----------------------------------------------------------------------------
// io_confirm_ctrl
// MMIO sequencer sitting between the Controller/ALU and the board I/O.
// - Switch reads (SW_ADDR) stall the core until a debounced confirm pulse
//   arrives, then return the switches latched on that edge for one HOLD cycle.
// - LED (LED_ADDR, low 16 bits) and 7-seg (SEG_ADDR, 32 bits) registers are
//   read combinationally with no stall and written on the clock edge.
//
// Ports:
//   clock      in   1   CPU clock
//   reset      in   1   synchronous, active-high
//   io_read    in   1   IORead from Controller
//   io_write   in   1   IOWrite from Controller
//   addr       in   32  IO address (ALU result)
//   wdata      in   32  store data
//   switches   in   16  board switches
//   confirm    in   1   one-cycle debounced confirm pulse
//   rdata      out  32  IO read data to MemOrIO
//   stall      out  1   hold PC / regfile write
//   led_out    out  16  LED register
//   seg_data   out  32  7-seg register
//   timed_out  out  1   sticky: last switch read ended by timeout
//
// Configuration macro: IO_CONFIRM_TIMEOUT_EN
//   Defined   -> a switch read also ends after TIMEOUT_CYCLES cycles in
//                WAIT_CONF without confirm, setting timed_out.
//   Undefined -> WAIT_CONF waits for confirm indefinitely; timed_out is 0.
// -----------------------------------------------------------------------------
module io_confirm_ctrl #(
    parameter logic [31:0] SW_ADDR        = 32'hFFFF_FC70,
    parameter logic [31:0] LED_ADDR       = 32'hFFFF_FC60,
    parameter logic [31:0] SEG_ADDR       = 32'hFFFF_FC80,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [15:0] switches,
    input  logic        confirm,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [15:0] led_out,
    output logic [31:0] seg_data,
    output logic        timed_out
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_CONF = 2'd1,
        ST_HOLD      = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] sw_latch_r;
    logic [15:0] led_r;
    logic [31:0] seg_r;
    logic        hit_sw_s;
    logic        hit_led_s;
    logic        hit_seg_s;
    logic        stall_s;
    logic        latch_s;
    logic        timeout_hit_s;
    logic        write_ok_s;
    logic [31:0] rdata_s;

    assign hit_sw_s  = (addr == SW_ADDR);
    assign hit_led_s = (addr == LED_ADDR);
    assign hit_seg_s = (addr == SEG_ADDR);

`ifdef IO_CONFIRM_TIMEOUT_EN
    logic [31:0] count_r;
    logic        timed_out_r;

    assign timeout_hit_s = (count_r == (TIMEOUT_CYCLES - 32'd1));

    // Confirm wait counter: cleared on entry to WAIT_CONF, counts every cycle there
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && (state_next_s == ST_WAIT_CONF)) begin
            count_r <= 32'd0;
        end else if (state_r == ST_WAIT_CONF) begin
            count_r <= count_r + 32'd1;
        end
    end

    // Sticky timeout flag: set by a timeout latch, cleared by a confirm latch
    always_ff @(posedge clock) begin
        if (reset) begin
            timed_out_r <= 1'b0;
        end else if (latch_s) begin
            timed_out_r <= ~confirm;
        end
    end

    assign timed_out = timed_out_r;
`else
    // The timeout length has no function when the timeout is compiled out.
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign timeout_hit_s    = 1'b0;
    assign timed_out        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, stall and latch-enable decode
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        latch_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Stall asserts in the request cycle itself so the PC holds at once.
                if (io_read && hit_sw_s) begin
                    stall_s      = 1'b1;
                    state_next_s = ST_WAIT_CONF;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_CONF: begin
                stall_s = 1'b1;
                // Confirm has priority over a timeout landing on the same cycle.
                if (confirm || timeout_hit_s) begin
                    latch_s      = 1'b1;
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_WAIT_CONF;
                end
            end
            ST_HOLD: begin
                // The stalled load commits here; a still-asserted read must not re-trigger.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Switch capture on the edge that ends the wait
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_latch_r <= 16'd0;
        end else if (latch_s) begin
            sw_latch_r <= switches;
        end
    end

    // A write is dropped when a read is asserted alongside it or the core is stalled.
    assign write_ok_s = io_write & ~io_read & ~stall_s;

    // LED and 7-seg data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            led_r <= 16'd0;
            seg_r <= 32'd0;
        end else begin
            if (write_ok_s && hit_led_s) begin
                led_r <= wdata[15:0];
            end
            if (write_ok_s && hit_seg_s) begin
                seg_r <= wdata;
            end
        end
    end

    // Read data mux: HOLD returns the latch, otherwise zero-latency register reads
    always_comb begin
        rdata_s = 32'd0;
        if (state_r == ST_HOLD) begin
            rdata_s = {16'd0, sw_latch_r};
        end else if (io_read && hit_led_s) begin
            rdata_s = {16'd0, led_r};
        end else if (io_read && hit_seg_s) begin
            rdata_s = seg_r;
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata    = rdata_s;
    assign stall    = stall_s;
    assign led_out  = led_r;
    assign seg_data = seg_r;

endmodule
